// File: rtl/row_demux.sv
// Row demultiplexer: steers each accepted input row to the next bank in round-robin order.
// Optional ROW_DEMUX_CNT_EN adds a saturating rows_written counter output.
module row_demux #(
    parameter int DW   = 1,
    parameter int POY  = 3,
    parameter int BUFW = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [15:0]                         cfg_rows,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BUFW-1:0][DW-1:0]             idata,
    output logic [POY-1:0][BUFW-1:0][DW-1:0]    odata,
    output logic [POY-1:0]                      owe,
    output logic [1:0]                          bank,
    output logic                                busy,
    output logic                                done
`ifdef ROW_DEMUX_CNT_EN
    ,
    output logic [15:0]                         rows_written
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_BANK = 2'(POY - 1);

    state_t      state_q;
    logic [15:0] rows_q;
    logic [15:0] rows_d;
    logic [1:0]  bank_q;
    logic [1:0]  bank_d;
    logic        done_q;
    logic        accept;

    logic [POY-1:0]                   owe_q;
    logic [POY-1:0][BUFW-1:0][DW-1:0] odata_q;

    assign accept = in_valid && (state_q == S_RUN);
    assign rows_d = rows_q - 16'd1;
    // With POY==1 LAST_BANK is 0, so the wrap keeps bank pinned at 0.
    assign bank_d = (bank_q == LAST_BANK) ? 2'd0 : bank_q + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rows_q  <= 16'd0;
            bank_q  <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bank_q <= 2'd0;
                        if (cfg_rows != 16'd0) begin
                            rows_q  <= cfg_rows;
                            state_q <= S_RUN;
                        end else begin
                            rows_q  <= 16'd0;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        rows_q <= rows_d;
                        bank_q <= bank_d;
                        if (rows_q == 16'd1) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // One register slice per bank; only the selected bank loads and strobes.
    generate
        for (genvar gi = 0; gi < POY; gi++) begin : g_bank
            logic sel;
            assign sel = accept && (bank_q == 2'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    owe_q[gi]   <= 1'b0;
                    odata_q[gi] <= '0;
                end else begin
                    owe_q[gi] <= sel;
                    if (sel) begin
                        odata_q[gi] <= idata;
                    end
                end
            end
        end
    endgenerate

    assign odata    = odata_q;
    assign owe      = owe_q;
    assign bank     = bank_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);
    assign in_ready = (state_q == S_RUN);

`ifdef ROW_DEMUX_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else if (start && (state_q == S_IDLE)) begin
            cnt_q <= 16'd0;
        end else if (accept && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign rows_written = cnt_q;
`endif

endmodule
